icache: RTL and testbench

//   Direct-mapped, one-word-per-line instruction cache between the fetch stage and mem_ctrl's IF port.

---
 rtl/icache_if.sv | 26 ++
 rtl/icache.sv | 113 +++++++++++
 tb/tb_icache.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Bundles the fetch-stage request/response signals and the mem_ctrl IF-port signals
// seen by the instruction cache.
interface icache_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_pc;
  logic              flush;
  logic              fetch_busy;
  logic              inst_valid;
  logic [31:0]       inst_out;
  logic              mc_if_enable;
  logic [ADDR_W-1:0] mc_if_addr;
  logic [31:0]       mc_if_inst;
  logic              mc_if_finished;

  modport slave (
    input  fetch_req, fetch_pc, flush, mc_if_inst, mc_if_finished,
    output fetch_busy, inst_valid, inst_out, mc_if_enable, mc_if_addr
  );

  modport master (
    output fetch_req, fetch_pc, flush, mc_if_inst, mc_if_finished,
    input  fetch_busy, inst_valid, inst_out, mc_if_enable, mc_if_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the fetch
// stage and the IF read port of mem_ctrl.
module icache #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 8
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    rdy_i,
  icache_if.slave bus
);

  localparam int TAG_W = ADDR_W - 2 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

  state_t                  state_q;
  logic                    busy_q;
  logic                    instValid_q;
  logic [31:0]             inst_q;
  logic                    en_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    kill_q;
  logic [INDEX_BITS-1:0]   pendIdx_q;
  logic [TAG_W-1:0]        pendTag_q;
  logic [31:0]             fill_q;
  logic [LINES-1:0]        lineValid_q;

  logic [31:0]             dataMem [LINES];
  logic [TAG_W-1:0]        tagMem  [LINES];

  logic [INDEX_BITS-1:0]   lookupIdx;
  logic [TAG_W-1:0]        lookupTag;
  logic                    hit;
  logic [1:0]              unusedPcBits;

  assign lookupIdx    = bus.fetch_pc[INDEX_BITS+1:2];
  assign lookupTag    = bus.fetch_pc[ADDR_W-1:INDEX_BITS+2];
  assign hit          = lineValid_q[lookupIdx] && (tagMem[lookupIdx] == lookupTag);
  assign unusedPcBits = bus.fetch_pc[1:0];

  assign bus.fetch_busy   = busy_q;
  assign bus.inst_valid   = instValid_q;
  assign bus.inst_out     = inst_q;
  assign bus.mc_if_enable = en_q;
  assign bus.mc_if_addr   = addr_q;

  // Data and tag arrays carry no reset; the valid bits alone decide residency.
  always_ff @(posedge clk_i) begin
    if (rdy_i && state_q == MISS && bus.mc_if_finished) begin
      dataMem[pendIdx_q] <= bus.mc_if_inst;
      tagMem[pendIdx_q]  <= pendTag_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      instValid_q <= 1'b0;
      inst_q      <= '0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      kill_q      <= 1'b0;
      pendIdx_q   <= '0;
      pendTag_q   <= '0;
      fill_q      <= '0;
      lineValid_q <= '0;
    end else if (rdy_i) begin
      instValid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (bus.fetch_req && !bus.flush) begin
            if (hit) begin
              inst_q      <= dataMem[lookupIdx];
              instValid_q <= 1'b1;
            end else begin
              en_q      <= 1'b1;
              addr_q    <= {bus.fetch_pc[ADDR_W-1:2], 2'b00};
              busy_q    <= 1'b1;
              pendIdx_q <= lookupIdx;
              pendTag_q <= lookupTag;
              state_q   <= MISS;
            end
          end
        end
        // A flush here only kills the response; the fill is still installed.
        MISS: begin
          if (bus.flush) kill_q <= 1'b1;
          if (bus.mc_if_finished) begin
            en_q                   <= 1'b0;
            fill_q                 <= bus.mc_if_inst;
            lineValid_q[pendIdx_q] <= 1'b1;
            state_q                <= RESP;
          end
        end
        RESP: begin
          if (!kill_q) begin
            inst_q      <= fill_q;
            instValid_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          kill_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written corner
// sequences, and randomized fetches against a residency model.
module tb_icache;

  logic clk = 1'b0;
  logic rstN;
  logic rdy;

  always #5 clk = ~clk;

  icache_if #(.ADDR_W(32)) bus ();

  icache #(.ADDR_W(32), .INDEX_BITS(8)) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .rdy_i  (rdy),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] pc;
    int          lat;
    int          flushAt;
    bit          expHit;
  } vec_t;

  vec_t        vecs [13];
  int          nVec  = 0;
  int          nMiss = 0;
  int unsigned lineOf [int];
  logic [31:0] lastInst = 32'h0;

  // Backing memory contents as a pure function of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0010_0093;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  function automatic int idxOf(input logic [31:0] pc);
    return int'(pc[9:2]);
  endfunction

  function automatic bit modelHit(input logic [31:0] pc);
    int i = idxOf(pc);
    return lineOf.exists(i) && (lineOf[i] == int'(pc >> 2));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One fetch: hit, or a full miss with a fill after 'lat' stall cycles and an
  // optional flush 'flushAt' cycles into the miss (flushAt == lat: same edge as finished).
  task automatic applyStimulus(input logic [31:0] pc, input int lat, input int flushAt, input bit expHit);
    logic [31:0] aligned = {pc[31:2], 2'b00};
    logic [31:0] w       = memWord(aligned);
    bit          killed  = 1'b0;
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = pc;
    step();
    bus.fetch_req = 1'b0;
    if (expHit) begin
      checkBit("hit_valid", bus.inst_valid, 1'b1);
      checkOutput("hit_inst", bus.inst_out, w);
      checkBit("hit_no_mem", bus.mc_if_enable, 1'b0);
      checkBit("hit_not_busy", bus.fetch_busy, 1'b0);
      lastInst = w;
    end else begin
      checkBit("miss_enable", bus.mc_if_enable, 1'b1);
      checkOutput("miss_addr", bus.mc_if_addr, aligned);
      checkBit("miss_busy", bus.fetch_busy, 1'b1);
      checkBit("miss_no_valid", bus.inst_valid, 1'b0);
      for (int c = 0; c < lat; c++) begin
        bus.flush = (c == flushAt);
        if (c == flushAt) killed = 1'b1;
        step();
        bus.flush = 1'b0;
        checkBit("stall_enable", bus.mc_if_enable, 1'b1);
        checkOutput("stall_addr", bus.mc_if_addr, aligned);
        checkBit("stall_no_valid", bus.inst_valid, 1'b0);
      end
      bus.flush          = (flushAt == lat);
      if (flushAt == lat) killed = 1'b1;
      bus.mc_if_finished = 1'b1;
      bus.mc_if_inst     = w;
      step();
      bus.mc_if_finished = 1'b0;
      bus.flush          = 1'b0;
      bus.mc_if_inst     = $urandom;
      checkBit("fill_enable_low", bus.mc_if_enable, 1'b0);
      checkBit("fill_no_valid", bus.inst_valid, 1'b0);
      checkBit("fill_busy", bus.fetch_busy, 1'b1);
      step();
      checkBit("resp_valid", bus.inst_valid, !killed);
      if (!killed) lastInst = w;
      checkOutput("resp_inst", bus.inst_out, lastInst);
      checkBit("resp_not_busy", bus.fetch_busy, 1'b0);
      lineOf[idxOf(pc)] = int'(pc >> 2);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h0000_0000, 3, -1, 1'b0};
    vecs[1]  = '{32'h0000_0000, 0, -1, 1'b1};
    vecs[2]  = '{32'h0000_0004, 1, -1, 1'b0};
    vecs[3]  = '{32'h0000_0004, 0, -1, 1'b1};
    vecs[4]  = '{32'h0000_0400, 2, -1, 1'b0};
    vecs[5]  = '{32'h0000_0000, 2, -1, 1'b0};
    vecs[6]  = '{32'h0000_0008, 4,  2, 1'b0};
    vecs[7]  = '{32'h0000_0008, 0, -1, 1'b1};
    vecs[8]  = '{32'h0000_0400, 0, -1, 1'b0};
    vecs[9]  = '{32'h0000_000C, 2,  2, 1'b0};
    vecs[10] = '{32'h0000_000D, 0, -1, 1'b1};
    vecs[11] = '{32'h0000_0000, 1, -1, 1'b0};
    vecs[12] = '{32'h0000_0004, 0, -1, 1'b1};

    rstN               = 1'b0;
    rdy                = 1'b1;
    bus.fetch_req      = 1'b0;
    bus.fetch_pc       = 32'h0;
    bus.flush          = 1'b0;
    bus.mc_if_inst     = 32'h0;
    bus.mc_if_finished = 1'b0;
    step();
    step();
    checkBit("rst_enable", bus.mc_if_enable, 1'b0);
    checkOutput("rst_addr", bus.mc_if_addr, 32'h0);
    checkBit("rst_busy", bus.fetch_busy, 1'b0);
    checkBit("rst_valid", bus.inst_valid, 1'b0);
    checkOutput("rst_inst", bus.inst_out, 32'h0);
    rstN = 1'b1;
    step();

    for (int i = 0; i < 13; i++)
      applyStimulus(vecs[i].pc, vecs[i].lat, vecs[i].flushAt, vecs[i].expHit);

    // Back-to-back hits on consecutive cycles, then the output holds.
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h0;
    step();
    checkBit("b2b_valid0", bus.inst_valid, 1'b1);
    checkOutput("b2b_inst0", bus.inst_out, 32'h0000_0013);
    bus.fetch_pc = 32'h4;
    step();
    checkBit("b2b_valid1", bus.inst_valid, 1'b1);
    checkOutput("b2b_inst1", bus.inst_out, 32'h0010_0093);
    checkBit("b2b_no_mem", bus.mc_if_enable, 1'b0);
    bus.fetch_req = 1'b0;
    step();
    checkBit("b2b_pulse_end", bus.inst_valid, 1'b0);
    checkOutput("b2b_hold", bus.inst_out, 32'h0010_0093);
    lastInst = 32'h0010_0093;

    // Flush in IDLE drops a same-cycle request, even a miss.
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h0000_0800;
    bus.flush     = 1'b1;
    step();
    bus.fetch_req = 1'b0;
    bus.flush     = 1'b0;
    checkBit("idle_flush_valid", bus.inst_valid, 1'b0);
    checkBit("idle_flush_enable", bus.mc_if_enable, 1'b0);
    checkBit("idle_flush_busy", bus.fetch_busy, 1'b0);

    // rdy low mid-miss: a finished pulse while stalled must be ignored.
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h0000_0010;
    step();
    bus.fetch_req = 1'b0;
    checkBit("rdy_miss_enable", bus.mc_if_enable, 1'b1);
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.mc_if_finished = (c == 2);
      bus.mc_if_inst     = memWord(32'h10);
      step();
      checkBit("rdy_hold_enable", bus.mc_if_enable, 1'b1);
      checkOutput("rdy_hold_addr", bus.mc_if_addr, 32'h10);
      checkBit("rdy_hold_busy", bus.fetch_busy, 1'b1);
      checkBit("rdy_hold_valid", bus.inst_valid, 1'b0);
    end
    bus.mc_if_finished = 1'b0;
    rdy = 1'b1;
    step();
    step();
    checkBit("rdy_still_waiting", bus.mc_if_enable, 1'b1);
    bus.mc_if_finished = 1'b1;
    step();
    bus.mc_if_finished = 1'b0;
    checkBit("rdy_fill_enable_low", bus.mc_if_enable, 1'b0);
    step();
    checkBit("rdy_resp_valid", bus.inst_valid, 1'b1);
    checkOutput("rdy_resp_inst", bus.inst_out, memWord(32'h10));
    lineOf[idxOf(32'h10)] = int'(32'h10 >> 2);
    lastInst = memWord(32'h10);

    // Asynchronous reset mid-miss drops the request at once and clears the cache.
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h0000_0014;
    step();
    bus.fetch_req = 1'b0;
    checkBit("arst_miss_enable", bus.mc_if_enable, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    checkBit("arst_enable", bus.mc_if_enable, 1'b0);
    checkBit("arst_busy", bus.fetch_busy, 1'b0);
    checkOutput("arst_inst", bus.inst_out, 32'h0);
    lineOf.delete();
    lastInst = 32'h0;
    step();
    #2;
    rstN = 1'b1;
    step();
    applyStimulus(32'h0, 2, -1, 1'b0);

    // Randomized fetches over a small address window to force hits and conflicts.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] pc;
      int          lat;
      int          fa;
      if ($urandom_range(0, 5) == 0) begin
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = $urandom;
        bus.flush     = 1'b1;
        step();
        bus.fetch_req = 1'b0;
        bus.flush     = 1'b0;
        checkBit("rnd_flush_drop", bus.inst_valid | bus.mc_if_enable, 1'b0);
      end
      pc  = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      lat = $urandom_range(0, 4);
      fa  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
      applyStimulus(pc, lat, fa, modelHit(pc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
